// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: Avalon-MM single-port RAM with pipelined reads, byte-enabled writes and post-reset zero fill
// Ports: clk, reset (sync, active-high), clken (0 freezes all state), chipselect/address/byteenable/read/write/writedata
//        (Avalon-MM slave request), readdata/readdatavalid (read response after READ_LATENCY clken-cycles),
//        waitrequest (1 while clearing, in reset or with clken=0).
// Optional: define ONCHIP_MEMORY_PARITY_EN to add per-byte even parity storage with parity_inject in and parity_error out.
module onchip_memory_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
`ifdef ONCHIP_MEMORY_PARITY_EN
  input  logic                    parity_inject,
  output logic                    parity_error,
`endif
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state;
  logic [AW-1:0]         clr_addr, idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, d1, nd, dq;
  logic                  in_range, acc, wr_en, rd_acc, v1, nv, vq;
  assign idx         = address[AW-1:0];
  assign in_range    = 32'(address) < DEPTH;
  assign waitrequest = reset | (state != READY) | ~clken;
  assign acc         = chipselect & (read | write) & ~waitrequest;
  assign wr_en       = acc & write & in_range;
  // a read issued together with a write is dropped
  assign rd_acc      = acc & read & ~write;
  assign rd_word     = in_range ? mem[idx] : '0;
  // latency 1 feeds the output register straight from the array, latency 2 goes through stage 1
  assign nv          = READ_LATENCY == 1 ? rd_acc : v1;
  assign nd          = READ_LATENCY == 1 ? rd_word : d1;
  // a valid held across a clken=0 stall is masked until clken returns, then shown exactly once
  assign readdatavalid = vq & clken & ~reset;
  assign readdata      = reset ? '0 : dq;
`ifdef ONCHIP_MEMORY_PARITY_EN
  logic [BYTES-1:0] par [DEPTH];
  logic [BYTES-1:0] wpar, rpar;
  logic             rd_err, e1, ne, eq;
  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int i = 0; i < BYTES; i++) begin
      wpar[i] = ^writedata[8*i +: 8] ^ parity_inject;
      rpar[i] = ^rd_word[8*i +: 8];
    end
  end
  assign rd_err       = in_range && (rpar != par[idx]);
  assign ne           = READ_LATENCY == 1 ? rd_err : e1;
  assign parity_error = eq & readdatavalid;
  always_ff @(posedge clk)
    if (clken) begin
      if (state == CLEAR) par[clr_addr] <= '0;
      else if (wr_en)
        for (int i = 0; i < BYTES; i++)
          if (byteenable[i]) par[idx][i] <= wpar[i];
    end
  always_ff @(posedge clk)
    if (reset) begin
      e1 <= 1'b0;
      eq <= 1'b0;
    end else if (clken) begin
      e1 <= rd_err;
      if (nv) eq <= ne;
    end
`endif
  always_ff @(posedge clk)
    if (clken) begin
      if (state == CLEAR) mem[clr_addr] <= '0;
      else if (wr_en)
        for (int i = 0; i < BYTES; i++)
          if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
    end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      v1       <= 1'b0;
      d1       <= '0;
      vq       <= 1'b0;
      dq       <= '0;
    end else if (clken) begin
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == AW'(DEPTH - 1)) state <= READY;
      end
      v1 <= rd_acc;
      d1 <= rd_word;
      vq <= nv;
      if (nv) dq <= nd;
    end
endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// tb_onchip_memory_pipelined: checks latency-1 and latency-2 instances side by side against a scoreboard and memory model
module tb_onchip_memory_pipelined;
  logic clk = 0, reset = 1, clken = 1, chipselect = 0, read = 0, write = 0, pinj = 0, use_tb = 0;
  logic [3:0]  address = 0, byteenable = 0;
  logic [31:0] writedata = 0, tb_exp = 0;
  logic [31:0] rdv [2];
  logic [1:0]  rv, wreq, pe;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct { logic [31:0] d; logic pe; int c; } exp_t;
  typedef struct { logic w; logic r; logic [3:0] a; logic [3:0] be; logic [31:0] wd; logic [31:0] ex; } vec_t;
  exp_t sbq [2][$];
  exp_t em;
  logic [31:0] mdl [16];
  logic [3:0]  mbad [16];
  vec_t vt [22];
  always #5 clk = ~clk;
  always @(posedge clk) if (clken) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(g + 1)) dut (
      .clk(clk), .reset(reset), .clken(clken), .chipselect(chipselect), .address(address),
      .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
`ifdef ONCHIP_MEMORY_PARITY_EN
      .parity_inject(pinj), .parity_error(pe[g]),
`endif
      .readdata(rdv[g]), .readdatavalid(rv[g]), .waitrequest(wreq[g]));
  end
`ifndef ONCHIP_MEMORY_PARITY_EN
  assign pe = '0;
`endif
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rv[k] === 1'b1) begin
        tests++;
        if (!clken || reset || sbq[k].size() == 0) begin
          fails++;
          $display("FAIL spurious_valid dut%0d: got valid=1 data=%h, required no valid (cyc %0d)", k, rdv[k], cyc);
        end else begin
          em = sbq[k].pop_front();
          if (rdv[k] !== em.d || cyc != em.c + k + 1) begin
            fails++;
            $display("FAIL read_data dut%0d: got %h at cyc %0d, required %h at cyc %0d", k, rdv[k], cyc, em.d, em.c + k + 1);
          end
`ifdef ONCHIP_MEMORY_PARITY_EN
          tests++;
          if (pe[k] !== em.pe) begin
            fails++;
            $display("FAIL parity_error dut%0d: got %b required %b", k, pe[k], em.pe);
          end
`endif
        end
      end else begin
        if (clken && !reset && sbq[k].size() > 0 && cyc >= sbq[k][0].c + k + 1) begin
          tests++;
          fails++;
          $display("FAIL missing_valid dut%0d: got no valid at cyc %0d, required data %h", k, cyc, sbq[k][0].d);
          void'(sbq[k].pop_front());
        end
        if (pe[k] === 1'b1) begin
          tests++;
          fails++;
          $display("FAIL parity_without_valid dut%0d: got 1 required 0", k);
        end
      end
    end
    if (!reset && clken && chipselect && wreq[0] === 1'b0 && (read || write)) begin
      if (write) begin
        if (address < 12)
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) begin
              mdl[address][8*i +: 8] = writedata[8*i +: 8];
              mbad[address][i] = pinj;
            end
      end else begin
        em.d  = use_tb ? tb_exp : (address < 12 ? mdl[address] : 32'h0);
        em.pe = address < 12 && |mbad[address];
        em.c  = cyc;
        sbq[0].push_back(em);
        sbq[1].push_back(em);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    chipselect = 0; read = 0; write = 0; pinj = 0; use_tb = 0;
  endtask
  task automatic op(input logic w, input logic r, input logic [3:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input logic [31:0] ex, input logic ue, input logic inj);
    chipselect = 1; write = w; read = r; address = a; byteenable = be; writedata = wd;
    tb_exp = ex; use_tb = ue; pinj = inj;
    step();
  endtask
  task automatic do_reset(input int n);
    int wc;
    reset = 1;
    idle();
    sbq[0].delete();
    sbq[1].delete();
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 0;
      mbad[i] = 0;
    end
    repeat (n) step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_readdata_dut%0d", k), rdv[k], 0);
      chk($sformatf("reset_valid_dut%0d", k), 32'(rv[k]), 0);
      chk($sformatf("reset_waitreq_dut%0d", k), 32'(wreq[k]), 1);
    end
    @(posedge clk);
    #1;
    reset = 0;
    wc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wreq[0] !== 1'b1) break;
      wc++;
    end
    chk("clear_wait_cycles", wc, 12);
    chk("ready_waitreq_dut1", 32'(wreq[1]), 0);
    step();
  endtask
  initial begin
    vt[0]  = '{1, 0, 4'd3,  4'hF, 32'hAABBCCDD, 32'h0};
    vt[1]  = '{1, 0, 4'd3,  4'h5, 32'h11223344, 32'h0};
    vt[2]  = '{0, 1, 4'd3,  4'hF, 32'h0,        32'hAA22CC44};
    vt[3]  = '{1, 0, 4'd0,  4'hF, 32'h1,        32'h0};
    vt[4]  = '{1, 0, 4'd1,  4'hF, 32'h2,        32'h0};
    vt[5]  = '{1, 0, 4'd2,  4'hF, 32'h3,        32'h0};
    vt[6]  = '{0, 1, 4'd0,  4'hF, 32'h0,        32'h1};
    vt[7]  = '{0, 1, 4'd1,  4'hF, 32'h0,        32'h2};
    vt[8]  = '{0, 1, 4'd2,  4'hF, 32'h0,        32'h3};
    vt[9]  = '{1, 0, 4'd13, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[10] = '{0, 1, 4'd13, 4'hF, 32'h0,        32'h0};
    vt[11] = '{0, 1, 4'd11, 4'hF, 32'h0,        32'h0};
    vt[12] = '{1, 0, 4'd7,  4'h2, 32'h0000AB00, 32'h0};
    vt[13] = '{0, 1, 4'd7,  4'hF, 32'h0,        32'h0000AB00};
    vt[14] = '{1, 1, 4'd4,  4'hF, 32'h00000055, 32'h0};
    vt[15] = '{0, 1, 4'd4,  4'hF, 32'h0,        32'h00000055};
    vt[16] = '{0, 1, 4'd5,  4'h0, 32'h0,        32'h0};
    vt[17] = '{1, 0, 4'd8,  4'h0, 32'hFFFFFFFF, 32'h0};
    vt[18] = '{0, 1, 4'd8,  4'hF, 32'h0,        32'h0};
    vt[19] = '{1, 0, 4'd11, 4'h8, 32'h99000000, 32'h0};
    vt[20] = '{0, 1, 4'd11, 4'hF, 32'h0,        32'h99000000};
    vt[21] = '{0, 1, 4'd15, 4'hF, 32'h0,        32'h0};
    do_reset(3);
    for (int a = 0; a < 12; a++) op(0, 1, 4'(a), 4'hF, 0, 0, 0, 0);
    idle();
    repeat (4) step();
    for (int i = 0; i < 22; i++) op(vt[i].w, vt[i].r, vt[i].a, vt[i].be, vt[i].wd, vt[i].ex, 1, 0);
    idle();
    repeat (4) step();
    op(0, 1, 4'd3, 4'hF, 0, 0, 0, 0);
    idle();
    clken = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall_valid_dut%0d", k), 32'(rv[k]), 0);
        chk($sformatf("stall_waitreq_dut%0d", k), 32'(wreq[k]), 1);
      end
      step();
    end
    clken = 1;
    repeat (4) step();
    op(0, 1, 4'd3, 4'hF, 0, 0, 0, 0);
    do_reset(3);
    op(1, 0, 4'd5, 4'hF, 32'h000000FF, 0, 0, 1);
    op(0, 1, 4'd5, 4'hF, 0, 0, 0, 0);
    op(1, 0, 4'd6, 4'hF, 32'h000000FF, 0, 0, 0);
    op(0, 1, 4'd6, 4'hF, 0, 0, 0, 0);
    op(0, 1, 4'd12, 4'hF, 0, 0, 0, 0);
    idle();
    repeat (5) step();
    chk("sb_empty_dut0", sbq[0].size(), 0);
    chk("sb_empty_dut1", sbq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
